// File: rtl/spi_xfer_ctrl_if.sv
// Host-side byte handshake of the SPI transaction sequencer.
// The slave modport is the sequencer and the master modport is the host logic.
interface spi_xfer_ctrl_if #(
    parameter int LEN_W = 4
);
    logic             start_i;
    logic             rw_i;
    logic [7:0]       addr_i;
    logic [LEN_W-1:0] len_i;
    logic [7:0]       wr_data_i;
    logic             wr_ready_o;
    logic [7:0]       rd_data_o;
    logic             rd_valid_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, rw_i, addr_i, len_i, wr_data_i,
        input  wr_ready_o, rd_data_o, rd_valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, rw_i, addr_i, len_i, wr_data_i,
        output wr_ready_o, rd_data_o, rd_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master sequencer for ADXL362 register accesses: one frame of
// [cmd][addr][len data bytes] per accepted start, MSB first, byte-level host handshake.
module spi_xfer_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    spi_xfer_ctrl_if.slave host,
    output logic           sclk_o,
    output logic           ncs_o,
    output logic           mosi_o,
    input  logic           miso_i
);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [LEN_W:0]   BYTE_ZERO = {(LEN_W+1){1'b0}};
    localparam logic [LEN_W:0]   BYTE_ONE  = (LEN_W+1)'(1);
    localparam logic [LEN_W:0]   BYTE_TWO  = (LEN_W+1)'(2);
    localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [7:0]       CMD_WR   = 8'h0A;
    localparam logic [7:0]       CMD_RD   = 8'h0B;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_q;
    logic [LEN_W:0]   byte_q;
    logic [LEN_W-1:0] len_q;
    logic             rw_q;
    logic [7:0]       addr_q;
    logic [6:0]       tx_q;
    logic [6:0]       rx_q;
    logic             sclk_q;
    logic             ncs_q;
    logic             mosi_q;
    logic             busy_q;
    logic             done_q;
    logic             wr_ready_q;
    logic             rd_valid_q;
    logic [7:0]       rd_data_q;

    logic             div_last_s;
    logic [DIV_W-1:0] div_nxt_s;
    logic             sclk_nxt_s;
    logic             last_byte_s;
    logic [7:0]       next_tx_s;
    logic [7:0]       rx_byte_s;
    logic             wr_load_next_s;

    // Divider/bit decode; wr_ready is raised one cycle ahead so it coincides with the byte-load cycle
    always_comb begin
        div_last_s     = (div_q == DIV_LAST);
        div_nxt_s      = div_last_s ? DIV_ZERO : (div_q + DIV_ONE);
        sclk_nxt_s     = div_last_s ? ~sclk_q : sclk_q;
        last_byte_s    = (byte_q == ({1'b0, len_q} + BYTE_ONE));
        next_tx_s      = (byte_q == BYTE_ZERO) ? addr_q
                                               : (rw_q ? 8'h00 : host.wr_data_i);
        rx_byte_s      = {rx_q, miso_i};
        wr_load_next_s = (state_q == S_SHIFT) && (bit_q == 3'd7) && !rw_q
                         && (byte_q != BYTE_ZERO) && !last_byte_s
                         && sclk_nxt_s && (div_nxt_s == DIV_LAST);
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= DIV_ZERO;
            bit_q      <= 3'd0;
            byte_q     <= BYTE_ZERO;
            len_q      <= LEN_ZERO;
            rw_q       <= 1'b0;
            addr_q     <= 8'h00;
            tx_q       <= 7'h00;
            rx_q       <= 7'h00;
            sclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            wr_ready_q <= wr_load_next_s;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    div_q  <= DIV_ZERO;
                    bit_q  <= 3'd0;
                    byte_q <= BYTE_ZERO;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    if (host.start_i && (host.len_i != LEN_ZERO)) begin
                        rw_q    <= host.rw_i;
                        addr_q  <= host.addr_i;
                        len_q   <= host.len_i;
                        tx_q    <= host.rw_i ? CMD_RD[6:0] : CMD_WR[6:0];
                        mosi_q  <= host.rw_i ? CMD_RD[7] : CMD_WR[7];
                        ncs_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end else begin
                        ncs_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                S_SETUP: begin
                    div_q <= div_nxt_s;
                    if (div_last_s) begin
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    div_q <= div_nxt_s;
                    if (div_last_s) begin
                        sclk_q <= ~sclk_q;
                        if (!sclk_q) begin
                            // Rising sclk: sample; only data bytes of a read reach the host
                            rx_q <= rx_byte_s[6:0];
                            if ((bit_q == 3'd7) && rw_q && (byte_q >= BYTE_TWO)) begin
                                rd_data_q  <= rx_byte_s;
                                rd_valid_q <= 1'b1;
                            end
                        end else if (bit_q == 3'd7) begin
                            bit_q <= 3'd0;
                            if (last_byte_s) begin
                                mosi_q  <= 1'b0;
                                state_q <= S_HOLD;
                            end else begin
                                byte_q <= byte_q + BYTE_ONE;
                                tx_q   <= next_tx_s[6:0];
                                mosi_q <= next_tx_s[7];
                            end
                        end else begin
                            bit_q  <= bit_q + 3'd1;
                            tx_q   <= {tx_q[5:0], 1'b0};
                            mosi_q <= tx_q[6];
                        end
                    end
                end
                S_HOLD: begin
                    div_q <= div_nxt_s;
                    if (div_last_s) begin
                        ncs_q   <= 1'b1;
                        done_q  <= (DIV_LAST == DIV_ZERO);
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    div_q  <= div_nxt_s;
                    done_q <= !div_last_s && (div_nxt_s == DIV_LAST);
                    if (div_last_s) begin
                        busy_q  <= 1'b0;
                        byte_q  <= BYTE_ZERO;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    div_q   <= DIV_ZERO;
                    sclk_q  <= 1'b0;
                    ncs_q   <= 1'b1;
                    mosi_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sclk_o          = sclk_q;
    assign ncs_o           = ncs_q;
    assign mosi_o          = mosi_q;
    assign host.wr_ready_o = wr_ready_q;
    assign host.rd_data_o  = rd_data_q;
    assign host.rd_valid_o = rd_valid_q;
    assign host.busy_o     = busy_q;
    assign host.done_o     = done_q;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a mode-0 slave model on the SPI pins.
// Expected bytes, counts and latencies are hand-computed constants.
module tb_spi_xfer_ctrl;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic miso_i = 1'b0;
    logic sclk_o;
    logic ncs_o;
    logic mosi_o;

    spi_xfer_ctrl_if #(.LEN_W(LEN_W)) host_if ();

    spi_xfer_ctrl #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .host   (host_if.slave),
        .sclk_o (sclk_o),
        .ncs_o  (ncs_o),
        .mosi_o (mosi_o),
        .miso_i (miso_i)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int rise_cnt  = 0;
    int ncs_rise  = 0;
    int wr_pulses = 0;
    int done_cnt  = 0;
    int viol      = 0;
    logic [7:0] slv_bytes [0:17];
    logic [7:0] wr_bytes  [0:15];
    logic [7:0] mosi_bytes [$];
    logic [7:0] rd_bytes   [$];
    logic [7:0] mosi_sh   = 8'h00;
    logic       ncs_seen  = 1'b1;
    logic       sclk_seen = 1'b0;
    logic       sclk_prev = 1'b0;
    logic       mosi_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic slv_bit(input int idx);
        int b;
        int k;
        if (idx < 0 || idx >= 144) return 1'b0;
        b = idx / 8;
        k = 7 - (idx % 8);
        return slv_bytes[b[4:0]][k[2:0]];
    endfunction

    function automatic logic [7:0] mb_at(input int idx);
        if (idx < mosi_bytes.size()) return mosi_bytes[idx];
        return 8'hEE;
    endfunction

    function automatic logic [7:0] rd_at(input int idx);
        if (idx < rd_bytes.size()) return rd_bytes[idx];
        return 8'hEE;
    endfunction

    // Slave model: capture MOSI on rising sclk, corrupt MISO while sclk is high, present next bit on falling sclk
    always @(ncs_o or sclk_o) begin
        if (ncs_o !== ncs_seen) begin
            if (ncs_o === 1'b0) begin
                rise_cnt = 0;
                miso_i   = slv_bit(0);
            end else begin
                ncs_rise++;
            end
        end else if (sclk_o === 1'b1 && sclk_seen === 1'b0 && ncs_o === 1'b0) begin
            mosi_sh = {mosi_sh[6:0], mosi_o};
            rise_cnt++;
            if (rise_cnt % 8 == 0) mosi_bytes.push_back(mosi_sh);
            miso_i = ~miso_i;
        end else if (sclk_o === 1'b0 && sclk_seen === 1'b1) begin
            miso_i = slv_bit(rise_cnt);
        end
        ncs_seen  = ncs_o;
        sclk_seen = sclk_o;
    end

    // Host model and pin-protocol watch, sampled 1 time unit after each clk edge
    always @(posedge clk) begin
        #1;
        host_if.wr_data_i = wr_bytes[wr_pulses[3:0]];
        if (host_if.wr_ready_o) wr_pulses++;
        if (host_if.rd_valid_o) rd_bytes.push_back(host_if.rd_data_o);
        if (host_if.done_o) done_cnt++;
        if (sclk_prev && sclk_o && (mosi_o !== mosi_prev)) viol++;
        if (ncs_o && (sclk_o || mosi_o)) viol++;
        sclk_prev = sclk_o;
        mosi_prev = mosi_o;
    end

    task automatic run_xfer(input logic rw, input logic [7:0] addr, input logic [3:0] len,
                            output int lat, output int busy_low);
        @(negedge clk);
        host_if.rw_i    = rw;
        host_if.addr_i  = addr;
        host_if.len_i   = len;
        host_if.start_i = 1'b1;
        lat      = -1;
        busy_low = 0;
        for (int k = 1; k <= 4000; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) host_if.start_i = 1'b0;
            if (!host_if.busy_o) busy_low++;
            if (host_if.done_o) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic int exp_lat(input int len);
        return CLK_DIV * (3 + 16 * (len + 2));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, bl, mb, rb, wb, db, nb, hi;
        host_if.start_i = 1'b0;
        host_if.rw_i    = 1'b0;
        host_if.addr_i  = 8'h00;
        host_if.len_i   = 4'd0;
        for (int i = 0; i < 18; i++) slv_bytes[i] = 8'h00;
        for (int i = 0; i < 16; i++) wr_bytes[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_pins", 32'({ncs_o, sclk_o, mosi_o, host_if.busy_o, host_if.done_o,
                                     host_if.wr_ready_o, host_if.rd_valid_o}), 32'b1000000);
        check_val("reset_rd_data", 32'(host_if.rd_data_o), 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // T1: write 0x2D len 1 data 0x02
        mb = mosi_bytes.size(); rb = rd_bytes.size(); wb = wr_pulses;
        wr_bytes[wb[3:0]] = 8'h02;
        run_xfer(1'b0, 8'h2D, 4'd1, lat, bl);
        @(posedge clk); #1;
        check_val("t1_latency", 32'(lat), 32'd102);
        check_val("t1_busy_gap", 32'(bl), 32'd0);
        check_val("t1_busy_after", 32'(host_if.busy_o), 32'd0);
        check_val("t1_sclk_rises", 32'(rise_cnt), 32'd24);
        check_val("t1_wr_ready", 32'(wr_pulses - wb), 32'd1);
        check_val("t1_rd_valid", 32'(rd_bytes.size() - rb), 32'd0);
        check_val("t1_mosi", {8'h00, mb_at(mb), mb_at(mb + 1), mb_at(mb + 2)}, 32'h000A2D02);

        // T2: read 0x00 len 1, slave answers 0xAD in the data byte
        slv_bytes[0] = 8'hFF; slv_bytes[1] = 8'h5A; slv_bytes[2] = 8'hAD;
        mb = mosi_bytes.size(); rb = rd_bytes.size(); wb = wr_pulses;
        run_xfer(1'b1, 8'h00, 4'd1, lat, bl);
        @(posedge clk); #1;
        check_val("t2_latency", 32'(lat), 32'(exp_lat(1)));
        check_val("t2_rd_valid", 32'(rd_bytes.size() - rb), 32'd1);
        check_val("t2_rd_byte", 32'(rd_at(rb)), 32'hAD);
        check_val("t2_rd_held", 32'(host_if.rd_data_o), 32'hAD);
        check_val("t2_wr_ready", 32'(wr_pulses - wb), 32'd0);
        check_val("t2_mosi", {8'h00, mb_at(mb), mb_at(mb + 1), mb_at(mb + 2)}, 32'h000B0000);

        // T3: read 0x0E len 6, slave answers 0x11..0x66
        slv_bytes[0] = 8'hC3; slv_bytes[1] = 8'h3C;
        for (int i = 0; i < 6; i++) slv_bytes[i + 2] = 8'((i + 1) * 17);
        mb = mosi_bytes.size(); rb = rd_bytes.size(); nb = ncs_rise;
        run_xfer(1'b1, 8'h0E, 4'd6, lat, bl);
        @(posedge clk); #1;
        check_val("t3_latency", 32'(lat), 32'(exp_lat(6)));
        check_val("t3_sclk_rises", 32'(rise_cnt), 32'd64);
        check_val("t3_ncs_rises", 32'(ncs_rise - nb), 32'd1);
        check_val("t3_rd_valid", 32'(rd_bytes.size() - rb), 32'd6);
        for (int i = 0; i < 6; i++)
            check_val($sformatf("t3_rd_byte%0d", i), 32'(rd_at(rb + i)), 32'((i + 1) * 17));
        check_val("t3_mosi_hdr", {16'h0000, mb_at(mb), mb_at(mb + 1)}, 32'h00000B0E);

        // T4: restart mid-transfer is ignored; a len=0 request is ignored
        mb = mosi_bytes.size(); wb = wr_pulses; db = done_cnt;
        wr_bytes[wb[3:0]] = 8'hA5; wr_bytes[4'(wb + 1)] = 8'h5A;
        fork
            run_xfer(1'b0, 8'h1F, 4'd2, lat, bl);
            begin
                repeat (30) @(negedge clk);
                host_if.start_i = 1'b1;
                host_if.rw_i    = 1'b1;
                host_if.addr_i  = 8'hFF;
                host_if.len_i   = 4'd3;
                @(negedge clk);
                host_if.start_i = 1'b0;
            end
        join
        repeat (4) @(posedge clk); #1;
        check_val("t4_latency", 32'(lat), 32'(exp_lat(2)));
        check_val("t4_done_count", 32'(done_cnt - db), 32'd1);
        check_val("t4_wr_ready", 32'(wr_pulses - wb), 32'd2);
        check_val("t4_mosi", {mb_at(mb), mb_at(mb + 1), mb_at(mb + 2), mb_at(mb + 3)}, 32'h0A1FA55A);
        db = done_cnt; hi = 0;
        @(negedge clk);
        host_if.start_i = 1'b1;
        host_if.rw_i    = 1'b0;
        host_if.len_i   = 4'd0;
        @(negedge clk);
        host_if.start_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (host_if.busy_o || !ncs_o) hi++;
        end
        check_val("t4_len0_busy", 32'(hi), 32'd0);
        check_val("t4_len0_done", 32'(done_cnt - db), 32'd0);

        // T5: reset during byte 2 bit 3, then a normal write
        db = done_cnt;
        wr_bytes[wr_pulses[3:0]] = 8'h77; wr_bytes[4'(wr_pulses + 1)] = 8'h88;
        @(negedge clk);
        host_if.rw_i    = 1'b0;
        host_if.addr_i  = 8'h33;
        host_if.len_i   = 4'd2;
        host_if.start_i = 1'b1;
        @(posedge clk); #1;
        host_if.start_i = 1'b0;
        hi = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (rise_cnt >= 20) begin
                hi = 1;
                break;
            end
        end
        check_val("t5_reached_bit", 32'(hi), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("t5_reset_pins", 32'({ncs_o, sclk_o, host_if.busy_o, host_if.done_o}), 32'b1000);
        check_val("t5_reset_rd_data", 32'(host_if.rd_data_o), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        check_val("t5_no_done", 32'(done_cnt - db), 32'd0);
        mb = mosi_bytes.size(); wb = wr_pulses;
        wr_bytes[wb[3:0]] = 8'h3C;
        run_xfer(1'b0, 8'h2C, 4'd1, lat, bl);
        @(posedge clk); #1;
        check_val("t5_latency", 32'(lat), 32'd102);
        check_val("t5_mosi", {8'h00, mb_at(mb), mb_at(mb + 1), mb_at(mb + 2)}, 32'h000A2C3C);

        // T6: pin-protocol rules held across every test
        check_val("t6_pin_rules", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
